// File: rtl/scan_pkg.sv
// Shared types for the scan link arbiter: FSM state encoding, scanner command codes,
// and the frame parity helper (present only when SCAN_ARB_PARITY_EN is defined).
package scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_CMD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP   = 3'd4
`ifdef SCAN_ARB_PARITY_EN
        , ST_PAR = 3'd5
`endif
    } state_e;

    localparam logic [7:0] CMD_READY_TO_TRANSFER = 8'd2;
    localparam logic [7:0] CMD_START_SCANNING    = 8'd3;
    localparam logic [7:0] CMD_BUFFER_FULL       = 8'd4;
    localparam logic [7:0] CMD_DATA_TRANSFER     = 8'd7;

`ifdef SCAN_ARB_PARITY_EN
    // Odd parity over the whole frame, given the XOR-reductions of its words.
    function automatic logic frame_parity(input logic cmd_xor, input logic dat_xor);
        return ~(cmd_xor ^ dat_xor);
    endfunction
`endif

endpackage

// File: rtl/scan_link_shifter.sv
// Load/shift PISO for the serial link, LSB first, with a saturating bit counter
// that restarts on every load or clear.
module scan_link_shifter #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              clear_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              ser_o,
    output logic              last_o
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state for shift register and bit counter
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sr_d  = word_i;
            cnt_d = '0;
        end else if (shift_i) begin
            sr_d  = {1'b0, sr_q[WORD_W-1:1]};
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    // Shift register and counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign ser_o  = sr_q[0];
    assign last_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/scan_link_arbiter.sv
// Round-robin arbiter granting two scanners a shared serial link; each frame is a
// command word plus optional data word. Optional frame parity: SCAN_ARB_PARITY_EN.
module scan_link_arbiter
    import scan_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        has_data,
    input  logic [WORD_W-1:0] cmd0,
    input  logic [WORD_W-1:0] cmd1,
    input  logic [WORD_W-1:0] dat0,
    input  logic [WORD_W-1:0] dat1,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic              clkOut,
    output logic              dataOut,
    output logic              busy
);

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYC - 1);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [2:0]        gap_q, gap_d;
    logic [WORD_W-1:0] dat_q;
    logic              hd_q;
    logic [1:0]        grant_q, grant_d, done_q, done_d;
    logic              strobe_q, strobe_d, busy_q, busy_d;
    logic              ld_s, sh_s, clr_s, last_bit_s, ser_s, owned_s;
    logic [WORD_W-1:0] word_s, cmd_sel_s, dat_sel_s;
    logic              hd_sel_s;
`ifdef SCAN_ARB_PARITY_EN
    logic              par_q;
`endif

    // During GRANT the pointer already names the new owner.
    assign cmd_sel_s = last_q ? cmd1 : cmd0;
    assign dat_sel_s = last_q ? dat1 : dat0;
    assign hd_sel_s  = last_q ? has_data[1] : has_data[0];

    // Arbiter FSM next-state and shifter control
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gap_d   = 3'd0;
        ld_s    = 1'b0;
        sh_s    = 1'b0;
        clr_s   = 1'b0;
        word_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_d = ST_GRANT;
                    if (req == 2'b11) last_d = ~last_q;
                    else              last_d = req[1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_d = ST_CMD;
                ld_s    = 1'b1;
                word_s  = cmd_sel_s;
            end
            ST_CMD, ST_DATA: begin
                if (!last_bit_s) begin
                    sh_s = 1'b1;
                end else if (state_q == ST_CMD && hd_q) begin
                    state_d = ST_DATA;
                    ld_s    = 1'b1;
                    word_s  = dat_q;
                end else begin
`ifdef SCAN_ARB_PARITY_EN
                    state_d = ST_PAR;
                    ld_s    = 1'b1;
                    word_s  = WORD_W'(par_q);
`else
                    state_d = ST_GAP;
                    clr_s   = 1'b1;
`endif
                end
            end
`ifdef SCAN_ARB_PARITY_EN
            ST_PAR: begin
                state_d = ST_GAP;
                clr_s   = 1'b1;
            end
`endif
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 3'd1;
            end
            default: begin
                state_d = ST_IDLE;
                clr_s   = 1'b1;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        owned_s = (state_d == ST_GRANT) || (state_d == ST_CMD) || (state_d == ST_DATA);
        strobe_d = (state_d == ST_CMD) || (state_d == ST_DATA);
`ifdef SCAN_ARB_PARITY_EN
        owned_s  = owned_s  || (state_d == ST_PAR);
        strobe_d = strobe_d || (state_d == ST_PAR);
`endif
        grant_d = owned_s ? (last_d ? 2'b10 : 2'b01) : 2'b00;
        busy_d  = (state_d != ST_IDLE);
        if ((state_d == ST_GAP) && (state_q != ST_GAP)) done_d = last_q ? 2'b10 : 2'b01;
        else                                           done_d = 2'b00;
    end

    // FSM state, round-robin pointer, gap counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            gap_q    <= 3'd0;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gap_q    <= gap_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    // Frame contents are captured once in GRANT so later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
            hd_q  <= 1'b0;
`ifdef SCAN_ARB_PARITY_EN
            par_q <= 1'b0;
`endif
        end else if (state_q == ST_GRANT) begin
            dat_q <= dat_sel_s;
            hd_q  <= hd_sel_s;
`ifdef SCAN_ARB_PARITY_EN
            par_q <= frame_parity(^cmd_sel_s, hd_sel_s & (^dat_sel_s));
`endif
        end else begin
            dat_q <= dat_q;
            hd_q  <= hd_q;
`ifdef SCAN_ARB_PARITY_EN
            par_q <= par_q;
`endif
        end
    end

    scan_link_shifter #(.WORD_W(WORD_W)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ld_s),
        .shift_i (sh_s),
        .clear_i (clr_s),
        .word_i  (word_s),
        .ser_o   (ser_s),
        .last_o  (last_bit_s)
    );

    assign grant   = grant_q;
    assign done    = done_q;
    assign clkOut  = strobe_q;
    assign dataOut = ser_s;
    assign busy    = busy_q;

endmodule

// File: tb/tb_scan_link_arbiter.sv
// Directed bench for scan_link_arbiter; frame bit patterns are hand-written,
// with the extra odd-parity bit appended when SCAN_ARB_PARITY_EN is defined.
module tb_scan_link_arbiter;
    import scan_pkg::*;

`ifdef SCAN_ARB_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, has_data, grant, done;
    logic [7:0] cmd0, cmd1, dat0, dat1;
    logic       clkOut, dataOut, busy;
    int         total = 0;
    int         bad = 0;

    scan_link_arbiter #(.WORD_W(8), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .has_data(has_data),
        .cmd0(cmd0), .cmd1(cmd1), .dat0(dat0), .dat1(dat1),
        .grant(grant), .done(done), .clkOut(clkOut), .dataOut(dataOut), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts in the IDLE cycle where req is already applied; ends on the following IDLE cycle.
    task automatic expect_frame(input logic [1:0] g, input logic [16:0] bits, input int n,
                                input logic [1:0] req_after, input int drop_at);
        @(negedge clk);
        chk("grant_cycle_grant", 16'(grant), 16'(g));
        chk("grant_cycle_clkOut", 16'(clkOut), 16'd0);
        chk("grant_cycle_busy", 16'(busy), 16'd1);
        req = req_after;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("bit%0d_clkOut", i), 16'(clkOut), 16'd1);
            chk($sformatf("bit%0d_dataOut", i), 16'(dataOut), 16'(bits[i]));
            chk($sformatf("bit%0d_grant", i), 16'(grant), 16'(g));
            chk($sformatf("bit%0d_done", i), 16'(done), 16'd0);
            if (i == drop_at) begin
                req  = 2'b00;
                cmd0 = 8'hFF;
            end
        end
        @(negedge clk);
        chk("gap1_done", 16'(done), 16'(g));
        chk("gap1_grant", 16'(grant), 16'd0);
        chk("gap1_clkOut", 16'(clkOut), 16'd0);
        chk("gap1_dataOut", 16'(dataOut), 16'd0);
        chk("gap1_busy", 16'(busy), 16'd1);
        @(negedge clk);
        chk("gap2_done", 16'(done), 16'd0);
        chk("gap2_busy", 16'(busy), 16'd1);
        chk("gap2_clkOut", 16'(clkOut), 16'd0);
        @(negedge clk);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_grant", 16'(grant), 16'd0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; has_data = 2'b00;
        cmd0 = 8'h00; cmd1 = 8'h00; dat0 = 8'h00; dat1 = 8'h00;
        @(negedge clk);
        chk("rst_grant", 16'(grant), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_clkOut", 16'(clkOut), 16'd0);
        chk("rst_dataOut", 16'(dataOut), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_req_busy", 16'(busy), 16'd0);

        // Scanner 0, command only
        req = 2'b01; cmd0 = CMD_READY_TO_TRANSFER; has_data = 2'b00;
        expect_frame(2'b01, {8'h00, 1'b0, 8'h02}, 8 + P, 2'b00, -1);

        // Scanner 1, command plus data
        req = 2'b10; cmd1 = CMD_DATA_TRANSFER; dat1 = 8'h09; has_data = 2'b10;
        expect_frame(2'b10, {1'b0, 8'h09, 8'h07}, 16 + P, 2'b00, -1);

        // Both requesting from reset: alternate 0,1,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmd0 = CMD_BUFFER_FULL; cmd1 = CMD_START_SCANNING; has_data = 2'b00; req = 2'b11;
        expect_frame(2'b01, {8'h00, 1'b0, 8'h04}, 8 + P, 2'b11, -1);
        expect_frame(2'b10, {8'h00, 1'b1, 8'h03}, 8 + P, 2'b11, -1);
        expect_frame(2'b01, {8'h00, 1'b0, 8'h04}, 8 + P, 2'b00, -1);

        // req dropped and cmd0 overwritten after 3 bits: original frame completes
        req = 2'b01; cmd0 = 8'h05; has_data = 2'b00;
        expect_frame(2'b01, {8'h00, 1'b1, 8'h05}, 8 + P, 2'b01, 2);

        // Reset during CMD bit 4 abandons the frame
        req = 2'b01; cmd0 = CMD_READY_TO_TRANSFER;
        @(negedge clk);
        chk("r_grant", 16'(grant), 16'd1);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("r_bit%0d", i), 16'(dataOut), 16'(i == 1));
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_grant", 16'(grant), 16'd0);
        chk("mid_rst_done", 16'(done), 16'd0);
        chk("mid_rst_clkOut", 16'(clkOut), 16'd0);
        chk("mid_rst_dataOut", 16'(dataOut), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b11; cmd0 = CMD_READY_TO_TRANSFER; cmd1 = CMD_DATA_TRANSFER;
        expect_frame(2'b01, {8'h00, 1'b0, 8'h02}, 8 + P, 2'b00, -1);

        // Command 0x03: parity bit (when present) is 1
        req = 2'b01; cmd0 = CMD_START_SCANNING; has_data = 2'b00;
        expect_frame(2'b01, {8'h00, 1'b1, 8'h03}, 8 + P, 2'b00, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
